otp_ctrl_part_buf_seq: RTL and testbench

// Sequencer for one buffered OTP partition's ECC register file (64bit words, SECDED 72/64).
// On init, reads every partition word from the OTP macro and writes it into the ECC register file.
// On demand, runs a consistency check: re-reads each OTP word and compares it to the buffered copy.

---
 rtl/otp_ctrl_part_buf_seq_pkg.sv | 34 +++
 rtl/otp_ctrl_part_buf_seq_if.sv | 45 ++++
 rtl/otp_ctrl_part_buf_seq.sv | 157 +++++++++++++++
 tb/tb_otp_ctrl_part_buf_seq.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/otp_ctrl_part_buf_seq_pkg.sv
`default_nettype none
//==============================================================================
// Module : otp_ctrl_part_buf_seq_pkg
// Brief  : State/error encodings and helpers for the partition buffer sequencer
// Rev    : 1.0
//==============================================================================
package otp_ctrl_part_buf_seq_pkg;

    // 6-bit shortened Hamming code words: every pair differs in >= 3 bits.
    typedef enum logic [5:0] {
        IDLE    = 6'b001011,
        INIT_RD = 6'b010101,
        INIT_WT = 6'b011110,
        INIT_WR = 6'b100110,
        READY   = 6'b101101,
        CHK_RD  = 6'b110011,
        CHK_WT  = 6'b111000,
        ERROR   = 6'b000000
    } state_e;

    typedef enum logic [2:0] {
        NoError    = 3'd0,
        OtpReadErr = 3'd1,
        CheckFail  = 3'd2,
        EccErr     = 3'd3,
        FsmErr     = 3'd4
    } err_code_e;

    function automatic int vbits(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/otp_ctrl_part_buf_seq_if.sv
`default_nettype none
//==============================================================================
// Module : otp_ctrl_part_buf_seq_if
// Brief  : Request, OTP read and ECC register file signals of the sequencer
// Rev    : 1.0
//==============================================================================
interface otp_ctrl_part_buf_seq_if #(
    parameter int OTP_AW = 11,
    parameter int AW     = 3
);
    import otp_ctrl_part_buf_seq_pkg::*;

    logic              init_req;
    logic              init_done;
    logic              chk_req;
    logic              chk_done;
    logic              otp_req;
    logic [OTP_AW-1:0] otp_addr;
    logic              otp_gnt;
    logic              otp_rvalid;
    logic [63:0]       otp_rdata;
    logic              otp_err;
    logic              reg_wren;
    logic [AW-1:0]     reg_addr;
    logic [63:0]       reg_wdata;
    logic [63:0]       reg_rdata;
    logic              ecc_err;
    err_code_e         error;

    modport master (
        input  init_req, chk_req, otp_gnt, otp_rvalid, otp_rdata, otp_err,
               reg_rdata, ecc_err,
        output init_done, chk_done, otp_req, otp_addr, reg_wren, reg_addr,
               reg_wdata, error
    );

    modport slave (
        output init_req, chk_req, otp_gnt, otp_rvalid, otp_rdata, otp_err,
               reg_rdata, ecc_err,
        input  init_done, chk_done, otp_req, otp_addr, reg_wren, reg_addr,
               reg_wdata, error
    );

endinterface
`default_nettype wire

// File: rtl/otp_ctrl_part_buf_seq.sv
`default_nettype none
//==============================================================================
// Module : otp_ctrl_part_buf_seq
// Brief  : Fills a partition's ECC register file from OTP and re-checks it
// Rev    : 1.0
//==============================================================================
module otp_ctrl_part_buf_seq
    import otp_ctrl_part_buf_seq_pkg::*;
#(
    parameter int DEPTH         = 8,
    parameter int OTP_AW        = 11,
    parameter int BASE_WORD_ADR = 0
) (
    input  wire logic               clk,
    input  wire logic               rst,
    otp_ctrl_part_buf_seq_if.master bus
);

    localparam int AW = vbits(DEPTH);

    state_e        r_state;
    logic [AW-1:0] r_cnt;
    logic [63:0]   r_data;
    err_code_e     r_error;
    logic          r_init_done;
    logic          r_chk_done;
    logic          r_otp_req;
    logic          r_reg_wren;

    state_e        w_state_nxt;
    err_code_e     w_err_nxt;
    logic [AW-1:0] w_cnt_nxt;
    logic          w_capture;
    logic          w_init_done_set;
    logic          w_chk_done_nxt;
    logic          w_last;

    assign w_last = (r_cnt == AW'(DEPTH - 1));

    always_comb begin
        w_state_nxt     = r_state;
        w_err_nxt       = r_error;
        w_cnt_nxt       = r_cnt;
        w_capture       = 1'b0;
        w_init_done_set = 1'b0;
        w_chk_done_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.init_req) w_state_nxt = INIT_RD;
            end
            INIT_RD: begin
                if (bus.otp_gnt) w_state_nxt = INIT_WT;
            end
            INIT_WT: begin
                if (bus.otp_rvalid) begin
                    if (bus.otp_err) begin
                        w_state_nxt = ERROR;
                        w_err_nxt   = OtpReadErr;
                    end else begin
                        w_capture   = 1'b1;
                        w_state_nxt = INIT_WR;
                    end
                end
            end
            INIT_WR: begin
                if (w_last) begin
                    w_cnt_nxt       = '0;
                    w_state_nxt     = READY;
                    w_init_done_set = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + AW'(1);
                    w_state_nxt = INIT_RD;
                end
            end
            READY: begin
                if (bus.chk_req) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = CHK_RD;
                end
            end
            CHK_RD: begin
                if (bus.otp_gnt) w_state_nxt = CHK_WT;
            end
            CHK_WT: begin
                if (bus.otp_rvalid) begin
                    if (bus.otp_err) begin
                        w_state_nxt = ERROR;
                        w_err_nxt   = OtpReadErr;
                    end else if (bus.otp_rdata != bus.reg_rdata) begin
                        w_state_nxt = ERROR;
                        w_err_nxt   = CheckFail;
                    end else if (w_last) begin
                        w_cnt_nxt      = '0;
                        w_state_nxt    = READY;
                        w_chk_done_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt   = r_cnt + AW'(1);
                        w_state_nxt = CHK_RD;
                    end
                end
            end
            ERROR: begin
                w_state_nxt = ERROR;
            end
            default: begin
                w_state_nxt = ERROR;
                w_err_nxt   = FsmErr;
            end
        endcase

        // An ECC alarm pre-empts whatever the current state decided this cycle.
        if (bus.ecc_err && (r_state != IDLE) && (r_state != ERROR)) begin
            w_state_nxt     = ERROR;
            w_err_nxt       = EccErr;
            w_cnt_nxt       = r_cnt;
            w_capture       = 1'b0;
            w_init_done_set = 1'b0;
            w_chk_done_nxt  = 1'b0;
        end

        if (r_error != NoError) w_err_nxt = r_error;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_data      <= '0;
            r_error     <= NoError;
            r_init_done <= 1'b0;
            r_chk_done  <= 1'b0;
            r_otp_req   <= 1'b0;
            r_reg_wren  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_error     <= w_err_nxt;
            r_init_done <= r_init_done | w_init_done_set;
            r_chk_done  <= w_chk_done_nxt;
            r_otp_req   <= (w_state_nxt == INIT_RD) || (w_state_nxt == CHK_RD);
            r_reg_wren  <= (w_state_nxt == INIT_WR);
            if (w_capture) r_data <= bus.otp_rdata;
        end
    end

    assign bus.init_done = r_init_done;
    assign bus.chk_done  = r_chk_done;
    assign bus.otp_req   = r_otp_req;
    assign bus.otp_addr  = OTP_AW'(BASE_WORD_ADR) + OTP_AW'(r_cnt);
    assign bus.reg_wren  = r_reg_wren;
    assign bus.reg_addr  = r_cnt;
    assign bus.reg_wdata = r_data;
    assign bus.error     = r_error;

endmodule
`default_nettype wire

// File: tb/tb_otp_ctrl_part_buf_seq.sv
`default_nettype none
//==============================================================================
// Module : tb_otp_ctrl_part_buf_seq
// Brief  : Scoreboard bench with OTP responder and register file models
// Rev    : 1.0
//==============================================================================
module tb_otp_ctrl_part_buf_seq;
    import otp_ctrl_part_buf_seq_pkg::*;

    localparam int DEPTH  = 8;
    localparam int OTP_AW = 11;
    localparam int BASE   = 4;
    localparam int AW     = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    otp_ctrl_part_buf_seq_if #(.OTP_AW(OTP_AW), .AW(AW)) bus();

    otp_ctrl_part_buf_seq #(
        .DEPTH(DEPTH), .OTP_AW(OTP_AW), .BASE_WORD_ADR(BASE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [63:0] otp_mem [DEPTH];
    logic [63:0] rf      [DEPTH];

    assign bus.otp_gnt   = bus.otp_req;
    assign bus.reg_rdata = rf[bus.reg_addr];

    always @(posedge clk) begin
        if (bus.reg_wren === 1'b1) rf[bus.reg_addr] <= bus.reg_wdata;
    end

    typedef struct {
        int               due;
        logic [OTP_AW-1:0] addr;
    } rsp_t;

    rsp_t              pend[$];
    int                cyc      = 0;
    int                rsp_lat  = 0;
    int                err_word = -1;
    logic [OTP_AW-1:0] last_rsp_addr = '0;

    // OTP responder: grant is immediate, response follows rsp_lat cycles later.
    always @(posedge clk) begin
        rsp_t r;
        cyc++;
        if (bus.otp_req === 1'b1 && !rst) pend.push_back('{cyc + rsp_lat, bus.otp_addr});
        #1;
        bus.otp_rvalid = 1'b0;
        bus.otp_rdata  = '0;
        bus.otp_err    = 1'b0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            r = pend.pop_front();
            last_rsp_addr  = r.addr;
            bus.otp_rvalid = 1'b1;
            bus.otp_rdata  = otp_mem[int'(r.addr) - BASE];
            bus.otp_err    = ((int'(r.addr) - BASE) == err_word);
        end
    end

    task automatic apply_rst();
        @(negedge clk);
        rst = 1'b1;
        bus.init_req = 1'b0;
        bus.chk_req  = 1'b0;
        bus.ecc_err  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_init();
        @(negedge clk);
        bus.init_req = 1'b1;
        @(negedge clk);
        bus.init_req = 1'b0;
    endtask

    task automatic pulse_chk();
        @(negedge clk);
        bus.chk_req = 1'b1;
        @(negedge clk);
        bus.chk_req = 1'b0;
    endtask

    // Full fill with scoreboarded writes and OTP addresses.
    task automatic run_init(input bit drop_chk, output int writes);
        logic [AW+63:0] exp_wr[$];
        int             exp_adr[$];
        logic [AW+63:0] e;
        int             ea;
        int             reqs = 0;
        int             first_c = -10;
        bit             done = 1'b0;
        writes = 0;
        for (int i = 0; i < DEPTH; i++) begin
            exp_wr.push_back({AW'(i), otp_mem[i]});
            exp_adr.push_back(BASE + i);
        end
        pulse_init();
        for (int c = 0; c < 300 && !done; c++) begin
            if (bus.otp_req === 1'b1) begin
                reqs++;
                if (reqs == 1) first_c = c;
                ea = (exp_adr.size() > 0) ? exp_adr.pop_front() : -1;
                n_chk++;
                if (int'(bus.otp_addr) !== ea) begin
                    n_fail++;
                    $display("FAIL init_otp_addr: got %0d want %0d", bus.otp_addr, ea);
                end
            end
            bus.chk_req = drop_chk && (c == first_c + 1);
            if (bus.reg_wren === 1'b1) begin
                writes++;
                e = (exp_wr.size() > 0) ? exp_wr.pop_front() : 'x;
                n_chk++;
                if ({bus.reg_addr, bus.reg_wdata} !== e) begin
                    n_fail++;
                    $display("FAIL init_write: got %0d/%h want %0d/%h",
                             bus.reg_addr, bus.reg_wdata, e[AW+63:64], e[63:0]);
                end
            end
            if (bus.init_done === 1'b1) done = 1'b1;
            else @(negedge clk);
        end
        bus.chk_req = 1'b0;
        n_chk++;
        if (done !== 1'b1 || exp_wr.size() != 0 || exp_adr.size() != 0) begin
            n_fail++;
            $display("FAIL init_complete: done %0d left_wr %0d left_adr %0d want 1/0/0",
                     done, exp_wr.size(), exp_adr.size());
        end
    endtask

    task automatic test_reset();
        apply_rst();
        n_chk++;
        if ({bus.init_done, bus.chk_done, bus.otp_req, bus.reg_wren} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0000",
                     {bus.init_done, bus.chk_done, bus.otp_req, bus.reg_wren});
        end
        n_chk++;
        if (bus.error !== NoError || bus.reg_wdata !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_err_data: got %0d/%h want 0/0", bus.error, bus.reg_wdata);
        end
        n_chk++;
        if (bus.reg_addr !== 3'd0 || int'(bus.otp_addr) !== BASE) begin
            n_fail++;
            $display("FAIL reset_addr: got %0d/%0d want 0/%0d", bus.reg_addr, bus.otp_addr, BASE);
        end
    endtask

    task automatic test_init();
        int w;
        bit stray = 1'b0;
        for (int i = 0; i < DEPTH; i++) otp_mem[i] = {$urandom, $urandom};
        run_init(1'b1, w);
        n_chk++;
        if (w !== DEPTH || bus.error !== NoError) begin
            n_fail++;
            $display("FAIL init_count: got %0d writes err %0d want %0d/0", w, bus.error, DEPTH);
        end
        repeat (10) begin
            @(negedge clk);
            if (bus.otp_req !== 1'b0 || bus.chk_done !== 1'b0) stray = 1'b1;
        end
        n_chk++;
        if (stray !== 1'b0) begin
            n_fail++;
            $display("FAIL dropped_chk_req: got activity %0d want 0", stray);
        end
    endtask

    task automatic test_check();
        int exp_adr[$];
        int ea;
        int wren = 0, pulses = 0, tail = 0;
        for (int i = 0; i < DEPTH; i++) exp_adr.push_back(BASE + i);
        pulse_chk();
        for (int c = 0; c < 200 && tail < 4; c++) begin
            if (bus.otp_req === 1'b1) begin
                ea = (exp_adr.size() > 0) ? exp_adr.pop_front() : -1;
                n_chk++;
                if (int'(bus.otp_addr) !== ea) begin
                    n_fail++;
                    $display("FAIL chk_otp_addr: got %0d want %0d", bus.otp_addr, ea);
                end
            end
            if (bus.reg_wren === 1'b1) wren++;
            if (bus.chk_done === 1'b1) pulses++;
            if (pulses > 0) tail++;
            @(negedge clk);
        end
        n_chk++;
        if (pulses !== 1 || wren !== 0 || exp_adr.size() != 0) begin
            n_fail++;
            $display("FAIL chk_pass: pulses %0d wren %0d left %0d want 1/0/0",
                     pulses, wren, exp_adr.size());
        end
        n_chk++;
        if (bus.error !== NoError || bus.init_done !== 1'b1) begin
            n_fail++;
            $display("FAIL chk_status: err %0d init_done %0d want 0/1", bus.error, bus.init_done);
        end
    endtask

    task automatic test_mismatch();
        int reqs = 0, pulses = 0;
        otp_mem[5][0] = ~otp_mem[5][0];
        pulse_chk();
        for (int c = 0; c < 120; c++) begin
            if (bus.otp_req === 1'b1) begin
                n_chk++;
                if (int'(bus.otp_addr) !== BASE + reqs) begin
                    n_fail++;
                    $display("FAIL mis_otp_addr: got %0d want %0d", bus.otp_addr, BASE + reqs);
                end
                reqs++;
            end
            if (bus.chk_done === 1'b1) pulses++;
            @(negedge clk);
        end
        n_chk++;
        if (bus.error !== CheckFail || reqs !== 6 || pulses !== 0) begin
            n_fail++;
            $display("FAIL mismatch: err %0d reqs %0d pulses %0d want 2/6/0",
                     bus.error, reqs, pulses);
        end
        otp_mem[5][0] = ~otp_mem[5][0];
    endtask

    task automatic test_otp_err();
        logic [AW+63:0] exp_wr[$];
        logic [AW+63:0] e;
        int             writes = 0, reqs = 0;
        apply_rst();
        err_word = 3;
        for (int i = 0; i < 3; i++) exp_wr.push_back({AW'(i), otp_mem[i]});
        pulse_init();
        for (int c = 0; c < 150; c++) begin
            if (bus.otp_req === 1'b1) reqs++;
            if (bus.reg_wren === 1'b1) begin
                writes++;
                e = (exp_wr.size() > 0) ? exp_wr.pop_front() : 'x;
                n_chk++;
                if ({bus.reg_addr, bus.reg_wdata} !== e) begin
                    n_fail++;
                    $display("FAIL err_write: got %0d/%h want %0d/%h",
                             bus.reg_addr, bus.reg_wdata, e[AW+63:64], e[63:0]);
                end
            end
            @(negedge clk);
        end
        err_word = -1;
        n_chk++;
        if (bus.error !== OtpReadErr || writes !== 3 || reqs !== 4 || bus.init_done !== 1'b0) begin
            n_fail++;
            $display("FAIL otp_err: err %0d writes %0d reqs %0d init_done %0d want 1/3/4/0",
                     bus.error, writes, reqs, bus.init_done);
        end
    endtask

    task automatic test_ecc();
        int w;
        int reqs = 0;
        apply_rst();
        run_init(1'b0, w);
        otp_mem[2] = otp_mem[2] ^ 64'h100;
        pulse_chk();
        for (int c = 0; c < 100; c++) begin
            if (bus.otp_req === 1'b1) reqs++;
            bus.ecc_err = (bus.otp_rvalid === 1'b1) && (int'(last_rsp_addr) == BASE + 2);
            @(negedge clk);
        end
        bus.ecc_err = 1'b0;
        otp_mem[2] = otp_mem[2] ^ 64'h100;
        n_chk++;
        if (bus.error !== EccErr || reqs !== 3 || w !== DEPTH) begin
            n_fail++;
            $display("FAIL ecc_priority: err %0d reqs %0d writes %0d want 3/3/%0d",
                     bus.error, reqs, w, DEPTH);
        end
    endtask

    task automatic test_rst_mid();
        int w;
        bit seen_req = 1'b0, seen_rv = 1'b0, bad = 1'b0;
        apply_rst();
        rsp_lat = 3;
        pulse_init();
        for (int c = 0; c < 20 && !seen_req; c++) begin
            if (bus.otp_req === 1'b1) seen_req = 1'b1;
            @(negedge clk);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (bus.otp_rvalid === 1'b1) seen_rv = 1'b1;
            if (bus.reg_wren !== 1'b0 || bus.otp_req !== 1'b0 ||
                bus.init_done !== 1'b0 || bus.error !== NoError) bad = 1'b1;
            @(negedge clk);
        end
        rsp_lat = 0;
        n_chk++;
        if (seen_req !== 1'b1 || seen_rv !== 1'b1 || bad !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_abort: req %0d late_rvalid %0d activity %0d want 1/1/0",
                     seen_req, seen_rv, bad);
        end
        run_init(1'b0, w);
        n_chk++;
        if (w !== DEPTH || bus.init_done !== 1'b1 || bus.error !== NoError) begin
            n_fail++;
            $display("FAIL reinit: writes %0d init_done %0d err %0d want %0d/1/0",
                     w, bus.init_done, bus.error, DEPTH);
        end
    endtask

    initial begin
        bus.init_req = 1'b0;
        bus.chk_req  = 1'b0;
        bus.ecc_err  = 1'b0;
        test_reset();
        test_init();
        test_check();
        test_mismatch();
        test_otp_err();
        test_ecc();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
